// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase round-robin traffic-light controller with gap/max-out green and flash mode
module traffic_phase_ctrl #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 10,
  parameter int YELLOW_T   = 2,
  parameter int ALLRED_T   = 1,
  parameter int FLASH_T    = 3,
  localparam int PW = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flash,
  input  logic [NUM_PHASES-1:0] req,
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] yellow,
  output logic [NUM_PHASES-1:0] red,
  output logic [PW-1:0]         phase,
  output logic [2:0]            state
);
  typedef enum logic [2:0] {IDLE = 3'd0, GREEN = 3'd1, YELLOW = 3'd2, ALL_RED = 3'd3, FLASH = 3'd4} state_t;
  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_PHASES-1:0] pend, pend_n, cur, clr;
  logic [PW-1:0] grant, phase_n;
  logic blink, blink_n, other, enter_green;
  int j;
  assign cur = NUM_PHASES'(1) << phase;
  assign other = |(pend & ~cur);
  // round-robin: nearest pending phase after the current one, wrapping back to itself last
  always_comb begin
    grant = phase;
    j = 0;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      j = (int'(phase) + k) % NUM_PHASES;
      if (pend[j]) grant = PW'(j);
    end
  end
  // next state; flash wins over every other transition
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = |pend ? GREEN : IDLE;
      GREEN:   st_n = other && ((cnt >= CNT_W'(GREEN_MIN - 1) && !req[phase]) || cnt >= CNT_W'(GREEN_MAX - 1)) ? YELLOW : GREEN;
      YELLOW:  st_n = cnt == CNT_W'(YELLOW_T - 1) ? ALL_RED : YELLOW;
      ALL_RED: st_n = cnt == CNT_W'(ALLRED_T - 1) ? (|pend ? GREEN : IDLE) : ALL_RED;
      FLASH:   st_n = flash ? FLASH : ALL_RED;
      default: st_n = IDLE;
    endcase
    if (flash) st_n = FLASH;
  end
  // datapath next values: timer, blink phase, request latch, granted phase
  always_comb begin
    enter_green = st_n == GREEN && st != GREEN;
    clr = enter_green ? NUM_PHASES'(1) << grant : '0;
    pend_n = (pend | (req & ~(st == GREEN ? cur : '0))) & ~clr;
    phase_n = enter_green ? grant : phase;
    cnt_n = st_n != st ? '0 :
            st == GREEN ? (cnt >= CNT_W'(GREEN_MAX - 1) ? cnt : cnt + 1'b1) :
            (st == FLASH && cnt == CNT_W'(FLASH_T - 1)) ? '0 : cnt + 1'b1;
    blink_n = st_n != FLASH ? 1'b0 : st != FLASH ? 1'b1 : cnt == CNT_W'(FLASH_T - 1) ? ~blink : blink;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      phase <= PW'(NUM_PHASES - 1);
      pend  <= '0;
      cnt   <= '0;
      blink <= 1'b0;
    end else begin
      st    <= st_n;
      phase <= phase_n;
      pend  <= pend_n;
      cnt   <= cnt_n;
      blink <= blink_n;
    end
  end
  assign state  = st;
  assign green  = st == GREEN ? cur : '0;
  assign yellow = (st == YELLOW ? cur : '0) | {NUM_PHASES{st == FLASH && blink}};
  assign red    = ~green & ~yellow;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed checks of reset, gap/max-out, round-robin, resting green and flash mode
module tb_traffic_phase_ctrl;
  logic clk = 0, reset = 0, flash = 0;
  logic [3:0] req = 0, green, yellow, red;
  logic [1:0] phase;
  logic [2:0] state;
  int checks = 0, failures = 0;

  traffic_phase_ctrl dut (.clk(clk), .reset(reset), .flash(flash), .req(req), .green(green),
    .yellow(yellow), .red(red), .phase(phase), .state(state));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 0; flash = 0; req = 0;
    tick();
    reset = 1;
  endtask

  task automatic to_green0();
    restart();
    req = 4'b0001;
    tick();
    req = 0;
    tick();
  endtask

  task automatic test_reset();
    reset = 0;
    tick();
    checks++;
    if (state !== 3'd0 || phase !== 2'd3 || red !== 4'hf || green !== 0 || yellow !== 0) begin
      failures++; $display("FAIL reset_state: state=%0d phase=%0d r=%b g=%b y=%b want 0 3 1111 0000 0000", state, phase, red, green, yellow);
    end
    reset = 1; req = 4'b0001;
    tick();
    req = 0;
    checks++;
    if (green !== 0 || state !== 3'd0) begin
      failures++; $display("FAIL latency_t1: green=%b state=%0d want 0000 0", green, state);
    end
    tick();
    checks++;
    if (green !== 4'b0001 || state !== 3'd1 || phase !== 2'd0) begin
      failures++; $display("FAIL latency_t2: green=%b state=%0d phase=%0d want 0001 1 0", green, state, phase);
    end
    tick(3);
    reset = 0;
    #1;
    checks++;
    if (state !== 3'd0 || phase !== 2'd3 || red !== 4'hf || green !== 0) begin
      failures++; $display("FAIL async_reset: state=%0d phase=%0d red=%b green=%b want 0 3 1111 0000", state, phase, red, green);
    end
    reset = 1;
  endtask

  task automatic test_max_out();
    int n;
    to_green0();
    req = 4'b0101;
    n = 1;
    tick();
    req = 4'b0001;
    while (green === 4'b0001 && n < 40) begin n++; tick(); end
    checks++;
    if (n !== 10) begin
      failures++; $display("FAIL max_out_len: got %0d cycles want 10", n);
    end
    req = 0;
    checks++;
    if (yellow !== 4'b0001 || state !== 3'd2) begin
      failures++; $display("FAIL max_out_yellow: yellow=%b state=%0d want 0001 2", yellow, state);
    end
    tick(2);
    checks++;
    if (state !== 3'd3 || red !== 4'hf) begin
      failures++; $display("FAIL max_out_allred: state=%0d red=%b want 3 1111", state, red);
    end
    tick();
    checks++;
    if (green !== 4'b0100 || phase !== 2'd2) begin
      failures++; $display("FAIL max_out_next: green=%b phase=%0d want 0100 2", green, phase);
    end
  endtask

  task automatic test_gap_out();
    int n;
    to_green0();
    req = 4'b0010;
    n = 1;
    tick();
    req = 0;
    while (green === 4'b0001 && n < 40) begin n++; tick(); end
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL gap_out_len: got %0d cycles want 4", n);
    end
    checks++;
    if (yellow !== 4'b0001 || green !== 0) begin
      failures++; $display("FAIL gap_out_yellow: yellow=%b green=%b want 0001 0000", yellow, green);
    end
  endtask

  task automatic test_round_robin();
    restart();
    req = 4'b0010;
    tick();
    req = 0;
    tick();
    checks++;
    if (green !== 4'b0010) begin
      failures++; $display("FAIL rr_first: green=%b want 0010", green);
    end
    req = 4'b1001;
    tick();
    req = 0;
    tick(6);
    checks++;
    if (green !== 4'b1000 || phase !== 2'd3) begin
      failures++; $display("FAIL rr_phase3: green=%b phase=%0d want 1000 3", green, phase);
    end
    tick(7);
    checks++;
    if (green !== 4'b0001 || phase !== 2'd0) begin
      failures++; $display("FAIL rr_wrap0: green=%b phase=%0d want 0001 0", green, phase);
    end
  endtask

  task automatic test_rest();
    int bad = 0;
    restart();
    req = 4'b0001;
    tick(2);
    for (int i = 0; i < 60; i++) begin
      if (green !== 4'b0001 || yellow !== 0) bad++;
      tick();
    end
    req = 0;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL rest_green: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_flash();
    logic [6:0] pat = 7'b1000111;
    int bad = 0;
    to_green0();
    req = 4'b0010;
    tick();
    req = 0;
    tick(3);
    checks++;
    if (state !== 3'd2) begin
      failures++; $display("FAIL flash_setup: state=%0d want 2", state);
    end
    flash = 1;
    tick();
    checks++;
    if (state !== 3'd4 || phase !== 2'd0) begin
      failures++; $display("FAIL flash_enter: state=%0d phase=%0d want 4 0", state, phase);
    end
    for (int i = 0; i < 7; i++) begin
      if (yellow !== {4{pat[i]}} || red !== {4{~pat[i]}} || green !== 0) bad++;
      if (i < 6) tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL flash_blink: %0d bad cycles want 0", bad);
    end
    flash = 0;
    tick();
    checks++;
    if (state !== 3'd3 || red !== 4'hf) begin
      failures++; $display("FAIL flash_exit: state=%0d red=%b want 3 1111", state, red);
    end
    tick();
    checks++;
    if (green !== 4'b0010 || phase !== 2'd1) begin
      failures++; $display("FAIL flash_resume: green=%b phase=%0d want 0010 1", green, phase);
    end
  endtask

  initial begin
    test_reset();
    test_max_out();
    test_gap_out();
    test_round_robin();
    test_rest();
    test_flash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
